// File: rtl/conv_sched.sv
// Convolution tap scheduler: walks a KxK window over an img_w x img_h image (stride 1, no padding)
// and issues one image/weight read address pair per unstalled cycle.
module conv_sched #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 10,
  parameter int K_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [K_W-1:0]    k,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              mac_first,
  output logic              mac_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      kx_q, kx_d, ky_q, ky_d, k_q, k_d, km1_q, km1_d;
  logic [DIM_W-1:0]    ox_q, ox_d, oy_q, oy_d, w_q, w_d;
  logic [DIM_W-1:0]    ox_max_q, ox_max_d, oy_max_q, oy_max_d;
  logic [ADDR_W-1:0]   img_base_q, img_base_d, wgt_base_q, wgt_base_d;
  logic [ADDR_W-1:0]   img_addr_q, img_addr_d, wgt_addr_q, wgt_addr_d;
  logic                first_q, first_d, last_q, last_d, err_q, err_d;
  logic                cfg_ok, last_tap, load;
  logic [ADDR_W-1:0]   row;

  assign cfg_ok   = (k != '0) && (DIM_W'(k) <= img_w) && (DIM_W'(k) <= img_h);
  assign last_tap = (kx_q == km1_q) && (ky_q == km1_q) &&
                    (ox_q == ox_max_q) && (oy_q == oy_max_q);

  always_comb begin
    state_d    = state_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    k_d        = k_q;
    km1_d      = km1_q;
    w_d        = w_q;
    ox_max_d   = ox_max_q;
    oy_max_d   = oy_max_q;
    img_base_d = img_base_q;
    wgt_base_d = wgt_base_q;
    img_addr_d = img_addr_q;
    wgt_addr_d = wgt_addr_q;
    first_d    = first_q;
    last_d     = last_q;
    err_d      = 1'b0;
    load       = 1'b0;
    row        = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d    = RUN;
            k_d        = k;
            km1_d      = k - K_W'(1);
            w_d        = img_w;
            ox_max_d   = img_w - DIM_W'(k);
            oy_max_d   = img_h - DIM_W'(k);
            img_base_d = img_base;
            wgt_base_d = wgt_base;
            kx_d       = '0;
            ky_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            load       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_tap) begin
            // Idle address outputs return to zero once the layer is finished.
            state_d    = DONE;
            img_addr_d = '0;
            wgt_addr_d = '0;
            first_d    = 1'b0;
            last_d     = 1'b0;
          end else begin
            load = 1'b1;
            if (kx_q != km1_q) begin
              kx_d = kx_q + K_W'(1);
            end else begin
              kx_d = '0;
              if (ky_q != km1_q) begin
                ky_d = ky_q + K_W'(1);
              end else begin
                ky_d = '0;
                if (ox_q != ox_max_q) begin
                  ox_d = ox_q + DIM_W'(1);
                end else begin
                  ox_d = '0;
                  oy_d = oy_q + DIM_W'(1);
                end
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Address of the tap that will be presented next cycle, from the updated counters.
    if (load) begin
      row        = ADDR_W'(oy_d) + ADDR_W'(ky_d);
      img_addr_d = img_base_d + row * ADDR_W'(w_d) + ADDR_W'(ox_d) + ADDR_W'(kx_d);
      wgt_addr_d = wgt_base_d + ADDR_W'(ky_d) * ADDR_W'(k_d) + ADDR_W'(kx_d);
      first_d    = (kx_d == '0) && (ky_d == '0);
      last_d     = (kx_d == km1_d) && (ky_d == km1_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      k_q        <= '0;
      km1_q      <= '0;
      w_q        <= '0;
      ox_max_q   <= '0;
      oy_max_q   <= '0;
      img_base_q <= '0;
      wgt_base_q <= '0;
      img_addr_q <= '0;
      wgt_addr_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      k_q        <= k_d;
      km1_q      <= km1_d;
      w_q        <= w_d;
      ox_max_q   <= ox_max_d;
      oy_max_q   <= oy_max_d;
      img_base_q <= img_base_d;
      wgt_base_q <= wgt_base_d;
      img_addr_q <= img_addr_d;
      wgt_addr_q <= wgt_addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign rd_en     = busy && !stall;
  assign mac_first = rd_en && first_q;
  assign mac_last  = rd_en && last_q;
  assign img_addr  = img_addr_q;
  assign wgt_addr  = wgt_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed, table-driven bench for conv_sched with a loop-based tap reference.
module tb_conv_sched;
  localparam int AW = 20;
  localparam int DW = 10;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] img_w = '0;
  logic [DW-1:0] img_h = '0;
  logic [KW-1:0] k = '0;
  logic [AW-1:0] img_base = '0;
  logic [AW-1:0] wgt_base = '0;
  logic          stall = 1'b0;
  logic          rd_en, mac_first, mac_last, busy, done, err;
  logic [AW-1:0] img_addr, wgt_addr;

  conv_sched #(.ADDR_W(AW), .DIM_W(DW), .K_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h), .k(k),
    .img_base(img_base), .wgt_base(wgt_base), .stall(stall), .rd_en(rd_en),
    .img_addr(img_addr), .wgt_addr(wgt_addr), .mac_first(mac_first),
    .mac_last(mac_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // busy, rd_en, mac_first, mac_last, done, err, img_addr, wgt_addr
  logic [45:0] outs;
  assign outs = {busy, rd_en, mac_first, mac_last, done, err, img_addr, wgt_addr};

  typedef struct {
    int w; int h; int k; int ib; int wb;
    int st_lo; int st_hi; int rs_cyc;
    int taps; int done_cyc; bit is_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] img; logic [AW-1:0] wgt; logic first; logic last;
  } tap_t;

  vec_t vecs[11];
  tap_t taps_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_model(input vec_t v);
    taps_q.delete();
    for (int oy = 0; oy <= v.h - v.k; oy++)
      for (int ox = 0; ox <= v.w - v.k; ox++)
        for (int ky = 0; ky < v.k; ky++)
          for (int kx = 0; kx < v.k; kx++) begin
            tap_t t;
            t.img   = AW'((v.ib + (oy + ky) * v.w + ox + kx) & 32'hFFFFF);
            t.wgt   = AW'((v.wb + ky * v.k + kx) & 32'hFFFFF);
            t.first = (kx == 0) && (ky == 0);
            t.last  = (kx == v.k - 1) && (ky == v.k - 1);
            taps_q.push_back(t);
          end
  endtask

  task automatic apply_start(input vec_t v);
    @(negedge clk);
    img_w = DW'(v.w); img_h = DW'(v.h); k = KW'(v.k);
    img_base = AW'(v.ib); wgt_base = AW'(v.wb);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int  t = 0;
    int  seen = 0;
    bit  fin = 1'b0;
    logic st;
    logic [45:0] exp;
    apply_start(v);
    if (v.is_err) begin
      @(negedge clk);
      check($sformatf("v%0d_err_pulse", idx), outs, {6'b000001, 40'b0});
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_err_clear", idx), outs, 46'b0);
      return;
    end
    build_model(v);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      st    = (cyc >= v.st_lo) && (cyc <= v.st_hi);
      stall = st;
      start = (cyc == v.rs_cyc);
      @(negedge clk);
      if (rd_en) seen++;
      if (t < taps_q.size()) begin
        exp = {1'b1, !st, !st && taps_q[t].first, !st && taps_q[t].last, 2'b00,
               taps_q[t].img, taps_q[t].wgt};
        check($sformatf("v%0d_tap%0d_c%0d", idx, t, cyc), outs, exp);
        if (!st) t++;
      end else begin
        check($sformatf("v%0d_done", idx), outs, {6'b000010, 40'b0});
        check_int($sformatf("v%0d_done_cycle", idx), cyc, v.done_cyc);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      stall = 1'b0;
      start = 1'b0;
      if (fin) break;
    end
    if (!fin) check_int($sformatf("v%0d_timeout", idx), 0, 1);
    check_int($sformatf("v%0d_tap_count", idx), seen, v.taps);
    @(negedge clk);
    check($sformatf("v%0d_back_idle", idx), outs, 46'b0);
  endtask

  initial begin
    vecs[0]  = '{4, 4, 3, 0, 0,             0, -1,  0, 36, 37, 1'b0};
    vecs[1]  = '{4, 4, 3, 0, 0,             5,  7,  0, 36, 40, 1'b0};
    vecs[2]  = '{3, 2, 1, 100, 50,          0, -1,  0,  6,  7, 1'b0};
    vecs[3]  = '{4, 4, 0, 0, 0,             0, -1,  0,  0,  0, 1'b1};
    vecs[4]  = '{4, 4, 5, 0, 0,             0, -1,  0,  0,  0, 1'b1};
    vecs[5]  = '{5, 3, 2, 1000, 7,          0, -1,  0, 32, 33, 1'b0};
    vecs[6]  = '{6, 3, 3, 0, 0,             0, -1,  0, 36, 37, 1'b0};
    vecs[7]  = '{8, 2, 3, 0, 0,             0, -1,  0,  0,  0, 1'b1};
    vecs[8]  = '{4, 4, 3, 0, 0,            36, 37,  0, 36, 39, 1'b0};
    vecs[9]  = '{4, 4, 3, 0, 0,             0, -1, 12, 36, 37, 1'b0};
    vecs[10] = '{4, 4, 3, 'hFFFFE, 'hFFFFF, 0, -1,  0, 36, 37, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", outs, 46'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_release", outs, 46'b0);

    for (int i = 0; i < 11; i++) run_case(i, vecs[i]);

    // Reset in cycle 10 of a running layer: everything clears, no done follows.
    apply_start(vecs[0]);
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_run_c11", outs, 46'b0);
    for (int cyc = 12; cyc < 50; cyc += 4) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_no_done_c%0d", cyc), outs, 46'b0);
    end
    run_case(100, vecs[0]);

    // Reset coinciding with a valid start: reset wins.
    @(negedge clk);
    img_w = 10'd4; img_h = 10'd4; k = 3'd3; img_base = '0; wgt_base = '0;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_c1", outs, 46'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_start_c2", outs, 46'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
